// File: rtl/roi_box_ctrl.sv
// roi_box_ctrl: on-screen region-of-interest box, positioned and resized by push buttons.
//
// The buttons edit a working geometry. Each axis has its own auto-repeat engine: one step
// on press, then one more after a hold delay, then one per repeat period. The working
// geometry is copied to the active geometry at frame_start. The active copy drives the
// cx/cy/half_w/half_h outputs and the per-pixel flags, so the box never tears mid-frame.
//
// Auto-repeat engine states (one engine per axis):
//   state  | meaning
//   IDLE   | no valid direction; the next valid press steps immediately
//   HOLD   | first step issued; counting down the initial hold delay
//   REPEAT | hold delay expired; stepping once per repeat period
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   move_up/down/left/right           level buttons (move or resize, depending on mode)
//   mode_toggle                       level; a rising edge flips resize_mode
//   frame_start                       one-cycle pulse; commits working geometry to active
//   x, y                              current pixel coordinate
//   draw_box, in_box, template_in_box pixel flags, registered (1-cycle latency from x, y)
//   cx, cy, half_w, half_h            active geometry
//   resize_mode                       0 = move, 1 = resize
module roi_box_ctrl #(
    parameter int H_RES         = 640,
    parameter int V_RES         = 480,
    parameter int CW            = 10,
    parameter int TEMPLATE_SIZE = 40,
    parameter int HALF_MIN      = 5,
    parameter int HALF_MAX      = 100,
    parameter int HALF_DEFAULT  = 100,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          move_up,
    input  logic          move_down,
    input  logic          move_left,
    input  logic          move_right,
    input  logic          mode_toggle,
    input  logic          frame_start,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    output logic          draw_box,
    output logic          in_box,
    output logic          template_in_box,
    output logic [CW-1:0] cx,
    output logic [CW-1:0] cy,
    output logic [CW-1:0] half_w,
    output logic [CW-1:0] half_h,
    output logic          resize_mode
);

    // The shipped defaults (HALF_MIN=5, TEMPLATE_SIZE=40) do not satisfy the
    // template-fits-minimum-box relation HALF_MIN >= TEMPLATE_SIZE/2. That check is
    // therefore left out, so that the default configuration still elaborates.
    // The checks below are hard errors.
    if (HALF_DEFAULT < HALF_MIN || HALF_DEFAULT > HALF_MAX) begin : g_bad_default
        $error("roi_box_ctrl: HALF_DEFAULT outside [HALF_MIN, HALF_MAX]");
    end
    if (2 * HALF_MAX + 1 > H_RES || 2 * HALF_MAX + 1 > V_RES) begin : g_bad_max
        $error("roi_box_ctrl: 2*HALF_MAX+1 exceeds screen size");
    end
    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_timing
        $error("roi_box_ctrl: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0]    CX_RST    = CW'(H_RES / 2);
    localparam logic [CW-1:0]    CY_RST    = CW'(V_RES / 2);
    localparam logic [CW-1:0]    HALF_RST  = CW'(HALF_DEFAULT);
    localparam logic [CW-1:0]    ONE_W     = CW'(1);
    localparam logic [CW:0]      ONE_E     = (CW + 1)'(1);
    localparam logic [CW:0]      X_LIM     = (CW + 1)'(H_RES - 1);
    localparam logic [CW:0]      Y_LIM     = (CW + 1)'(V_RES - 1);
    localparam logic [CW:0]      HMAX_E    = (CW + 1)'(HALF_MAX);
    localparam logic [CW:0]      HMIN_P1   = (CW + 1)'(HALF_MIN + 1);
    localparam logic [CW:0]      T_HALF    = (CW + 1)'(TEMPLATE_SIZE / 2);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;

    // Axis 0 = horizontal (pos = right), axis 1 = vertical (pos = down).
    rpt_state_e       state_q [2];
    rpt_state_e       state_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       axis_pos, axis_neg, step;
    logic             mode_prev_q, mode_edge;

    logic [CW-1:0] wcx_q, wcy_q, whw_q, whh_q, wcx_d, wcy_d, whw_d, whh_d;
    logic [CW-1:0] acx_q, acy_q, ahw_q, ahh_q, acx_d, acy_d, ahw_d, ahh_d;
    logic          resize_q, resize_d;
    logic          draw_box_q, in_box_q, tpl_q, draw_box_d, in_box_d, tpl_d;

    assign axis_pos  = {move_down, move_right};
    assign axis_neg  = {move_up, move_left};
    assign mode_edge = mode_toggle & ~mode_prev_q;

    // A mode change forces both engines to IDLE. Held buttons then count as fresh presses.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            state_d[a] = state_q[a];
            cnt_d[a]   = cnt_q[a];
            dir_d[a]   = dir_q[a];
            step[a]    = 1'b0;
            if (mode_edge || (axis_pos[a] == axis_neg[a])) begin
                state_d[a] = IDLE;
                cnt_d[a]   = '0;
            end else if (state_q[a] == IDLE || axis_pos[a] != dir_q[a]) begin
                step[a]    = 1'b1;
                cnt_d[a]   = HOLD_LOAD;
                state_d[a] = HOLD;
                dir_d[a]   = axis_pos[a];
            end else if (cnt_q[a] == '0) begin
                step[a]    = 1'b1;
                cnt_d[a]   = REP_LOAD;
                state_d[a] = REPEAT;
            end else begin
                cnt_d[a] = cnt_q[a] - 1'b1;
            end
        end
    end

    logic [CW:0] e_cx, e_cy, e_hw, e_hh;
    assign e_cx = {1'b0, wcx_q};
    assign e_cy = {1'b0, wcy_q};
    assign e_hw = {1'b0, whw_q};
    assign e_hh = {1'b0, whh_q};

    always_comb begin
        wcx_d    = wcx_q;
        wcy_d    = wcy_q;
        whw_d    = whw_q;
        whh_d    = whh_q;
        resize_d = resize_q ^ mode_edge;
        if (step[0]) begin
            if (!resize_q) begin
                if (axis_pos[0]) begin
                    if (e_cx + e_hw + ONE_E <= X_LIM) wcx_d = wcx_q + ONE_W;
                end else if (e_cx >= e_hw + ONE_E) begin
                    wcx_d = wcx_q - ONE_W;
                end
            end else if (axis_pos[0]) begin
                if (e_hw + ONE_E <= HMAX_E && e_cx >= e_hw + ONE_E && e_cx + e_hw + ONE_E <= X_LIM)
                    whw_d = whw_q + ONE_W;
            end else if (e_hw >= HMIN_P1) begin
                whw_d = whw_q - ONE_W;
            end
        end
        // Vertical resize: up grows, down shrinks.
        if (step[1]) begin
            if (!resize_q) begin
                if (axis_pos[1]) begin
                    if (e_cy + e_hh + ONE_E <= Y_LIM) wcy_d = wcy_q + ONE_W;
                end else if (e_cy >= e_hh + ONE_E) begin
                    wcy_d = wcy_q - ONE_W;
                end
            end else if (!axis_pos[1]) begin
                if (e_hh + ONE_E <= HMAX_E && e_cy >= e_hh + ONE_E && e_cy + e_hh + ONE_E <= Y_LIM)
                    whh_d = whh_q + ONE_W;
            end else if (e_hh >= HMIN_P1) begin
                whh_d = whh_q - ONE_W;
            end
        end
    end

    always_comb begin
        acx_d = frame_start ? wcx_q : acx_q;
        acy_d = frame_start ? wcy_q : acy_q;
        ahw_d = frame_start ? whw_q : ahw_q;
        ahh_d = frame_start ? whh_q : ahh_q;
    end

    logic [CW:0] e_x, e_y, a_cx, a_cy, a_hw, a_hh;
    logic        x_in, y_in, x_edge, y_edge, x_tpl, y_tpl;
    assign e_x  = {1'b0, x};
    assign e_y  = {1'b0, y};
    assign a_cx = {1'b0, acx_q};
    assign a_cy = {1'b0, acy_q};
    assign a_hw = {1'b0, ahw_q};
    assign a_hh = {1'b0, ahh_q};

    // Lower bounds are written as x + h >= c, so that no subtraction is needed.
    always_comb begin
        x_in       = (e_x + a_hw >= a_cx) && (e_x <= a_cx + a_hw);
        y_in       = (e_y + a_hh >= a_cy) && (e_y <= a_cy + a_hh);
        x_edge     = (e_x + a_hw == a_cx) || (e_x == a_cx + a_hw);
        y_edge     = (e_y + a_hh == a_cy) || (e_y == a_cy + a_hh);
        x_tpl      = (e_x + T_HALF >= a_cx) && (e_x < a_cx + T_HALF);
        y_tpl      = (e_y + T_HALF >= a_cy) && (e_y < a_cy + T_HALF);
        in_box_d   = x_in && y_in;
        draw_box_d = x_in && y_in && (x_edge || y_edge);
        tpl_d      = x_tpl && y_tpl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0]  <= IDLE;
            state_q[1]  <= IDLE;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            dir_q       <= '0;
            mode_prev_q <= 1'b0;
            wcx_q       <= CX_RST;
            wcy_q       <= CY_RST;
            whw_q       <= HALF_RST;
            whh_q       <= HALF_RST;
            acx_q       <= CX_RST;
            acy_q       <= CY_RST;
            ahw_q       <= HALF_RST;
            ahh_q       <= HALF_RST;
            resize_q    <= 1'b0;
            draw_box_q  <= 1'b0;
            in_box_q    <= 1'b0;
            tpl_q       <= 1'b0;
        end else begin
            state_q[0]  <= state_d[0];
            state_q[1]  <= state_d[1];
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            dir_q       <= dir_d;
            mode_prev_q <= mode_toggle;
            wcx_q       <= wcx_d;
            wcy_q       <= wcy_d;
            whw_q       <= whw_d;
            whh_q       <= whh_d;
            acx_q       <= acx_d;
            acy_q       <= acy_d;
            ahw_q       <= ahw_d;
            ahh_q       <= ahh_d;
            resize_q    <= resize_d;
            draw_box_q  <= draw_box_d;
            in_box_q    <= in_box_d;
            tpl_q       <= tpl_d;
        end
    end

    assign cx              = acx_q;
    assign cy              = acy_q;
    assign half_w          = ahw_q;
    assign half_h          = ahh_q;
    assign resize_mode     = resize_q;
    assign draw_box        = draw_box_q;
    assign in_box          = in_box_q;
    assign template_in_box = tpl_q;

endmodule

// File: tb/tb_roi_box_ctrl.sv
module tb_roi_box_ctrl;
    localparam int CW = 10, H = 640, V = 480, T = 40;
    localparam int HMIN = 5, HMAX = 100, HDEF = 100, HOLD = 4, REP = 2;

    logic          clk, rst, mu, md, ml, mr, mt, fs;
    logic [CW-1:0] x, y, cx, cy, half_w, half_h;
    logic          draw_box, in_box, template_in_box, resize_mode;

    roi_box_ctrl #(
        .H_RES(H), .V_RES(V), .CW(CW), .TEMPLATE_SIZE(T), .HALF_MIN(HMIN),
        .HALF_MAX(HMAX), .HALF_DEFAULT(HDEF), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst), .move_up(mu), .move_down(md), .move_left(ml),
        .move_right(mr), .mode_toggle(mt), .frame_start(fs), .x(x), .y(y),
        .draw_box(draw_box), .in_box(in_box), .template_in_box(template_in_box),
        .cx(cx), .cy(cy), .half_w(half_w), .half_h(half_h), .resize_mode(resize_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cx; int cy; int hw; int hh; int rm; int db; int ib; int tb;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0, n_total = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // Reference model: the state of the box, and for each axis the cycle at which the
    // current press began. Steps fall at press age 0, HOLD, HOLD+REP, ...
    int m_wcx, m_wcy, m_whw, m_whh, m_acx, m_acy, m_ahw, m_ahh, m_rm, m_prev_mode, m_t;
    int m_press[2], m_dir[2];
    bit s_rst, s_r, s_l, s_u, s_d, s_mode, s_frame;
    int s_x, s_y;

    task automatic model_reset();
        m_wcx = H / 2; m_wcy = V / 2; m_whw = HDEF; m_whh = HDEF;
        m_acx = H / 2; m_acy = V / 2; m_ahw = HDEF; m_ahh = HDEF;
        m_rm = 0; m_prev_mode = 0; m_press[0] = -1; m_press[1] = -1;
    endtask

    function automatic bit fits(input int c, input int h, input int lim);
        return (c - h >= 0) && (c + h <= lim);
    endfunction

    task automatic drive_and_model();
        exp_t e;
        bit   step[2], pos[2], neg[2], medge;
        int   k, nc, nh, l, r, tp, bt, owcx, owcy, owhw, owhh;
        rst = s_rst; mr = s_r; ml = s_l; mu = s_u; md = s_d; mt = s_mode; fs = s_frame;
        x = CW'(s_x); y = CW'(s_y);
        if (s_rst) begin
            model_reset();
            e = '{H / 2, V / 2, HDEF, HDEF, 0, 0, 0, 0};
        end else begin
            l = m_acx - m_ahw; r = m_acx + m_ahw; tp = m_acy - m_ahh; bt = m_acy + m_ahh;
            e.ib = (s_x >= l && s_x <= r && s_y >= tp && s_y <= bt) ? 1 : 0;
            e.db = (e.ib == 1 && (s_x == l || s_x == r || s_y == tp || s_y == bt)) ? 1 : 0;
            e.tb = (s_x >= m_acx - T / 2 && s_x < m_acx + T / 2 &&
                    s_y >= m_acy - T / 2 && s_y < m_acy + T / 2) ? 1 : 0;
            medge = s_mode && (m_prev_mode == 0);
            pos[0] = s_r; neg[0] = s_l; pos[1] = s_d; neg[1] = s_u;
            for (int a = 0; a < 2; a++) begin
                step[a] = 1'b0;
                if (medge || pos[a] == neg[a]) m_press[a] = -1;
                else if (m_press[a] < 0 || m_dir[a] != int'(pos[a])) begin
                    step[a] = 1'b1; m_press[a] = m_t; m_dir[a] = int'(pos[a]);
                end else begin
                    k = m_t - m_press[a];
                    if (k >= HOLD && (k - HOLD) % REP == 0) step[a] = 1'b1;
                end
            end
            owcx = m_wcx; owcy = m_wcy; owhw = m_whw; owhh = m_whh;
            if (step[0]) begin
                if (m_rm == 0) begin
                    nc = m_wcx + (pos[0] ? 1 : -1);
                    if (fits(nc, m_whw, H - 1)) m_wcx = nc;
                end else begin
                    nh = m_whw + (pos[0] ? 1 : -1);
                    if (nh >= HMIN && nh <= HMAX && fits(m_wcx, nh, H - 1)) m_whw = nh;
                end
            end
            if (step[1]) begin
                if (m_rm == 0) begin
                    nc = m_wcy + (pos[1] ? 1 : -1);
                    if (fits(nc, m_whh, V - 1)) m_wcy = nc;
                end else begin
                    nh = m_whh + (pos[1] ? -1 : 1);
                    if (nh >= HMIN && nh <= HMAX && fits(m_wcy, nh, V - 1)) m_whh = nh;
                end
            end
            if (s_frame) begin
                m_acx = owcx; m_acy = owcy; m_ahw = owhw; m_ahh = owhh;
            end
            if (medge) m_rm = 1 - m_rm;
            m_prev_mode = s_mode ? 1 : 0;
            e.cx = m_acx; e.cy = m_acy; e.hw = m_ahw; e.hh = m_ahh; e.rm = m_rm;
        end
        m_t++;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        drive_and_model();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        s_rst = 1; s_r = 0; s_l = 0; s_u = 0; s_d = 0; s_mode = 0; s_frame = 0;
        tick(); tick();
        s_rst = 0;
    endtask

    task automatic frame_tick();
        s_frame = 1; tick(); s_frame = 0; settle();
    endtask

    exp_t me;
    always @(posedge clk) begin
        #1;
        while (sb_q.size() > 0) begin
            me = sb_q.pop_front();
            chk("cx", int'(cx), me.cx);
            chk("cy", int'(cy), me.cy);
            chk("half_w", int'(half_w), me.hw);
            chk("half_h", int'(half_h), me.hh);
            chk("resize_mode", int'(resize_mode), me.rm);
            chk("draw_box", int'(draw_box), me.db);
            chk("in_box", int'(in_box), me.ib);
            chk("template_in_box", int'(template_in_box), me.tb);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hold_left, v;
        logic [3:0] pk;
        rst = 1; mu = 0; md = 0; ml = 0; mr = 0; mt = 0; fs = 0; x = '0; y = '0;
        s_x = 0; s_y = 0; m_t = 0; m_dir[0] = 0; m_dir[1] = 0;
        model_reset();
        do_reset();

        // Held right: steps at press ages 0, 4, 6, 8.
        s_r = 1; repeat (10) tick(); s_r = 0;
        frame_tick();
        chk("hold_right_cx", int'(cx), 324);

        // Both horizontal buttons pressed: no direction, so no step.
        do_reset();
        s_l = 1; s_r = 1; repeat (8) tick(); s_l = 0; s_r = 0;
        frame_tick();
        chk("both_lr_cx", int'(cx), 320);

        // Left sweep against the screen edge.
        do_reset();
        s_l = 1;
        for (int i = 0; i < 480; i++) begin
            s_frame = (i % 40 == 39); tick();
        end
        s_l = 0; s_frame = 0;
        frame_tick();
        chk("left_edge_cx", int'(cx), 100);

        // Resize: shrink once, grow back and clamp at HALF_MAX, then shrink to HALF_MIN.
        do_reset();
        s_mode = 1; tick(); s_mode = 0;
        s_d = 1; repeat (3) tick(); s_d = 0;
        frame_tick();
        chk("resize_mode_on", int'(resize_mode), 1);
        chk("shrink_half_h", int'(half_h), 99);
        s_u = 1; repeat (10) tick(); s_u = 0;
        frame_tick();
        chk("grow_cap_half_h", int'(half_h), 100);
        s_l = 1;
        for (int i = 0; i < 250; i++) begin
            s_frame = (i % 25 == 24); tick();
        end
        s_l = 0; s_frame = 0;
        frame_tick();
        chk("shrink_min_half_w", int'(half_w), 5);

        // Pixel flags with default geometry.
        do_reset();
        s_x = 220; s_y = 240; tick(); settle();
        chk("edge_draw_box", int'(draw_box), 1);
        chk("edge_in_box", int'(in_box), 1);
        chk("edge_template", int'(template_in_box), 0);
        s_x = 340; s_y = 259; tick(); settle();
        chk("tpl_right_excl", int'(template_in_box), 0);
        s_x = 339; tick(); settle();
        chk("tpl_right_incl", int'(template_in_box), 1);

        // Mode toggle while a button is held restarts the press in the new mode.
        do_reset();
        s_l = 1; repeat (6) tick();
        s_mode = 1; tick(); s_mode = 0;
        repeat (6) tick(); s_l = 0;
        frame_tick();
        chk("toggle_held_cx", int'(cx), 318);
        chk("toggle_held_half_w", int'(half_w), 98);

        // Asynchronous reset during REPEAT with the button still held.
        do_reset();
        s_x = 320; s_y = 240; s_r = 1;
        repeat (8) tick();
        frame_tick();
        chk("pre_rst_cx", int'(cx), 323);
        chk("pre_rst_in_box", int'(in_box), 1);
        @(negedge clk);
        s_rst = 1; drive_and_model();
        #1;
        chk("arst_cx", int'(cx), 320);
        chk("arst_half_w", int'(half_w), 100);
        chk("arst_in_box", int'(in_box), 0);
        chk("arst_template", int'(template_in_box), 0);
        s_rst = 0;
        repeat (4) tick(); s_r = 0;
        frame_tick();
        chk("post_rst_cx", int'(cx), 321);

        // Randomized traffic checked against the model every cycle.
        do_reset();
        hold_left = 0;
        for (int i = 0; i < 900; i++) begin
            if (hold_left == 0) begin
                pk = 4'($urandom_range(0, 15));
                s_r = pk[0]; s_l = pk[1]; s_u = pk[2]; s_d = pk[3];
                hold_left = $urandom_range(1, 14);
            end
            hold_left--;
            if ($urandom_range(0, 24) == 0) s_mode = ~s_mode;
            s_frame = ($urandom_range(0, 5) == 0);
            s_rst = ($urandom_range(0, 299) == 0);
            v = m_acx - m_ahw - 2 + $urandom_range(0, 2 * m_ahw + 4);
            s_x = (v < 0) ? 0 : v;
            v = m_acy - m_ahh - 2 + $urandom_range(0, 2 * m_ahh + 4);
            s_y = (v < 0) ? 0 : v;
            tick();
        end
        s_rst = 0; s_frame = 0;
        tick();
        settle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
